// File: rtl/store_write_unit.sv
// store_write_unit
//   Store path of the MEM stage. Each accepted store is turned into a lane-aligned
//   word write with byte enables. The result is queued in an in-order buffer that
//   drains to the data-memory write port under a req/ack handshake.
//   Optional feature macro: MISALIGN_CHECK_EN. When defined, misaligned word and
//   half-word stores are consumed but dropped, and st_misalign pulses once.
module store_write_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    output logic                       st_ready,
    input  logic [1:0]                 st_digit,
    input  logic [AW-1:0]              st_addr,
    input  logic [31:0]                st_data,
    output logic                       mem_req,
    output logic [AW-3:0]              mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_be,
    input  logic                       mem_ack,
    output logic [$clog2(DEPTH):0]     sb_count,
    output logic                       sb_empty,
    output logic                       st_misalign
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10,
        SZ_NONE = 2'b11
    } size_e;

    typedef struct packed {
        logic [AW-3:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
    } entry_t;

    entry_t          buf_q [DEPTH];
    entry_t          new_entry;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [AW-3:0]   last_addr;
    logic [31:0]     last_wdata;
    logic            misaligned;
    logic            push;
    logic            pop;

    // Lane alignment and byte-enable generation for the incoming request.
    always_comb begin
        // NOTE: every field gets a default first, so no path through the case infers a latch.
        new_entry.addr  = st_addr[AW-1:2];
        new_entry.wdata = st_data;
        new_entry.be    = 4'b1111;
        case (size_e'(st_digit))
            SZ_HALF: begin
                new_entry.wdata = {2{st_data[15:0]}};
                new_entry.be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            SZ_BYTE: begin
                new_entry.wdata = {4{st_data[7:0]}};
                new_entry.be    = 4'b0001 << st_addr[1:0];
            end
            default: ;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    logic accept;
    assign accept     = st_valid && st_ready;
    assign misaligned = ((st_digit == SZ_WORD) && (st_addr[1:0] != 2'b00)) ||
                        ((st_digit == SZ_HALF) && st_addr[0]);

    // One-cycle flag raised after a misaligned request has been consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_misalign <= 1'b0;
        else        st_misalign <= accept && misaligned;
    end
`else
    assign misaligned  = 1'b0;
    assign st_misalign = 1'b0;
`endif

    assign st_ready = (count != FULL);
    assign push     = st_valid && st_ready && (st_digit != SZ_NONE) && !misaligned;
    assign sb_empty = (count == '0);
    assign sb_count = count;
    assign mem_req  = !sb_empty;
    assign pop      = mem_req && mem_ack;

    // Entry storage: written at the tail on push.
    always_ff @(posedge clk) begin
        // NOTE: the data array is deliberately left out of reset; count and pointers decide validity.
        if (push) buf_q[wr_ptr] <= new_entry;
    end

    // Pointer, occupancy and last-drained address/data bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            last_addr  <= '0;
            last_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                last_addr  <= head.addr;
                last_wdata <= head.wdata;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head      = buf_q[rd_ptr];
    assign mem_addr  = sb_empty ? last_addr  : head.addr;
    assign mem_wdata = sb_empty ? last_wdata : head.wdata;
    assign mem_be    = sb_empty ? 4'b0000    : head.be;

endmodule
